counter_event_capture: RTL and testbench
========================================

// Module: counter_event_capture
// PURPOSE
//  Downstream consumer of the free-running 12-bit up counter (async, active-high reset).
//  Timestamps rising edges of event_in with the current counter value.
//  Computes the wrap-aware interval since the previous event.
//  Buffers {stamp, delta, first} in a small FWFT FIFO drained via valid/ready.
//  Used for period/jitter measurement against the counter timebase.
// PARAMETERS
//  CNT_W  12  counter/stamp width; must match the upstream counter width
//  DEPTH  4   FIFO entries; power of 2, >= 2
//  AW     2   log2(DEPTH); level output is AW+1 bits wide
// PORTS
//  clk        in   1      clock; same clock as the upstream counter
//  reset      in   1      asynchronous, active-high reset
//  count      in   CNT_W  counter value, sampled as-is (no resync)
//  event_in   in   1      event level, already synchronous to clk
//  clear      in   1      sync clear: flush FIFO, clear status, re-arm first
//  out_valid  out  1      FIFO head valid (not empty)
//  out_ready  in   1      consumer accepts head when out_valid & out_ready
//  out_stamp  out  CNT_W  count captured at the event
//  out_delta  out  CNT_W  (stamp - previous stamp) mod 2^CNT_W; 0 when first
//  out_first  out  1      entry is the first capture since reset/clear
//  level      out  AW+1   occupied entries, 0..DEPTH
//  overflow   out  1      sticky: at least one event dropped because FIFO full
//  drop_cnt   out  8      dropped-event count, saturates at 255
// BEHAVIOUR
//  Reset values: FIFO empty (out_valid=0, level=0), overflow=0, drop_cnt=0,
//    out_stamp/out_delta/out_first=0, last_stamp=0, armed_first=1, event_q=1.
//    event_q=1 means an event held high through reset does not capture.
//  Edge detect: edge = event_in & ~event_q; event_q <= event_in every cycle.
//  Capture: on the edge in cycle N, stamp = count as seen in cycle N.
//    delta = armed_first ? 0 : (count - last_stamp) truncated to CNT_W.
//    Truncation handles wrap: last=0xFF0, now=0x010 -> delta=0x020.
//  last_stamp <= count on every edge, including dropped edges.
//    Delta is therefore always relative to the immediately preceding event.
//  armed_first clears on the first edge after reset/clear, whether pushed or dropped.
//    out_first=1 only on an entry pushed while armed.
//  Push: edge & ~full_eff, where full_eff = (level==DEPTH) & ~pop.
//    Pop in the same cycle frees a slot; a push on a full FIFO with a pop is accepted.
//  Drop: edge & full_eff -> overflow<=1 and drop_cnt<=sat(drop_cnt+1). Entry discarded.
//  Pop: out_valid & out_ready. Head advances next cycle.
//    out_* hold stable while out_valid & ~out_ready.
//  Head data is driven from the FIFO head slot (FWFT).
//  Latency: edge in cycle N -> out_valid=1 in cycle N+1 with that entry if FIFO was empty.
//  Level update: push-only +1; pop-only -1; push+pop unchanged.
//    No push or pop when empty: out_ready ignored while out_valid=0.
//  Pointers wrap modulo DEPTH.
//  clear (sync, priority over pop) flushes the FIFO and zeroes overflow and drop_cnt.
//    It also sets armed_first=1 and zeroes last_stamp.
//    An edge in the clear cycle is then pushed as the first entry into the empty FIFO.
//    level=1 next cycle, out_first=1.
//  Reset asserted mid-operation: all state returns to reset values immediately.
//    In-flight FIFO contents are lost.
//  Back-to-back edges need event_in low for >=1 cycle between them.
//    Maximum capture rate is one event per 2 cycles.
// TESTING
//  1. Reset with event_in=1 held, release -> no capture, level=0.
//     Then fall and rise at count=0x064 -> stamp=0x064, delta=0, first=1.
//  2. Edges at count 0x100 then 0x1F4, out_ready=1 -> second entry has delta=0x0F4, first=0.
//  3. Wrap: edges at 0xFF0 then 0x010 -> delta=0x020.
//  4. out_ready=0, 6 edges with DEPTH=4 -> level=4, overflow=1, drop_cnt=2.
//     Then drain 4 entries; entries 1-4 are in order and stamps are unchanged.
//  5. FIFO full, edge with pop in the same cycle -> accepted, level stays 4, overflow unchanged.
//  6. clear in the same cycle as an edge at 0x321 -> level=1, stamp=0x321, first=1, delta=0.
//     overflow=0 and drop_cnt=0.
//     Async reset mid-drain -> out_valid=0 with no clock edge required.

Source files
------------

// File: rtl/counter_event_capture.sv
// Event timestamp capture against the shared free-running counter.
// Rising edges of event_in are stamped with the counter value and paired with
// the wrap-aware interval to the previous event, then queued in a small
// first-word-fall-through FIFO that the consumer drains via valid/ready.
module counter_event_capture #(
  parameter int CNT_W = 12,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic             event_in,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_stamp,
  output logic [CNT_W-1:0] out_delta,
  output logic             out_first,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic             event_q;
  logic             armed_first;
  logic [CNT_W-1:0] last_stamp;

  logic [CNT_W-1:0] mem_stamp [DEPTH];
  logic [CNT_W-1:0] mem_delta [DEPTH];
  logic             mem_first [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             overflow_q;
  logic [7:0]       drop_q;

  logic             edge_det;
  logic             pop;
  logic             full_eff;
  logic             push;
  logic             drop;
  logic             armed_eff;
  logic [CNT_W-1:0] last_eff;
  logic [CNT_W-1:0] new_delta;
  logic [AW-1:0]    wr_idx;

  // Edge detect plus push/pop/drop decisions; clear acts as if the FIFO and
  // the interval history were already flushed this cycle, so a coincident
  // edge lands as the first entry of an empty FIFO.
  always_comb begin
    edge_det  = event_in & ~event_q;
    pop       = out_valid & out_ready & ~clear;
    full_eff  = clear ? 1'b0 : ((level_q == FULL_LVL) & ~pop);
    push      = edge_det & ~full_eff;
    drop      = edge_det & full_eff;
    armed_eff = clear | armed_first;
    last_eff  = clear ? '0 : last_stamp;
    new_delta = armed_eff ? '0 : (count - last_eff);
    wr_idx    = clear ? '0 : wr_ptr;
  end

  // Edge history, interval reference and first-capture arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_q     <= 1'b1;
      armed_first <= 1'b1;
      last_stamp  <= '0;
    end else begin
      event_q <= event_in;
      if (edge_det) begin
        last_stamp  <= count;
        armed_first <= 1'b0;
      end else if (clear) begin
        last_stamp  <= '0;
        armed_first <= 1'b1;
      end
    end
  end

  // FIFO storage, pointers, occupancy and drop statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_stamp[i] <= '0;
        mem_delta[i] <= '0;
        mem_first[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push) begin
        mem_stamp[wr_idx] <= count;
        mem_delta[wr_idx] <= new_delta;
        mem_first[wr_idx] <= armed_eff;
      end
      if (clear) begin
        rd_ptr     <= '0;
        wr_ptr     <= push ? AW'(1) : '0;
        level_q    <= push ? (AW+1)'(1) : '0;
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push & ~pop)      level_q <= level_q + (AW+1)'(1);
        else if (pop & ~push) level_q <= level_q - (AW+1)'(1);
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
      end
    end
  end

  // Head slot drives the outputs directly (first-word fall-through).
  always_comb begin
    out_valid = (level_q != '0);
    out_stamp = mem_stamp[rd_ptr];
    out_delta = mem_delta[rd_ptr];
    out_first = mem_first[rd_ptr];
    level     = level_q;
    overflow  = overflow_q;
    drop_cnt  = drop_q;
  end

endmodule

// File: tb/tb_counter_event_capture.sv
// Bench for counter_event_capture: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_counter_event_capture;

  localparam int CNT_W = 12;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] count;
  logic             event_in;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_stamp;
  logic [CNT_W-1:0] out_delta;
  logic             out_first;
  logic [AW:0]      level;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  counter_event_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .count(count), .event_in(event_in),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_stamp(out_stamp), .out_delta(out_delta), .out_first(out_first),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of captured entries plus event history.
  typedef struct {
    logic [CNT_W-1:0] stamp;
    logic [CNT_W-1:0] delta;
    logic             first;
  } ent_t;

  ent_t             q[$];
  logic             m_prev;
  logic             m_armed;
  logic [CNT_W-1:0] m_last;
  logic             m_over;
  int               m_drops;

  task automatic model_reset();
    q.delete();
    m_prev  = 1'b1;
    m_armed = 1'b1;
    m_last  = '0;
    m_over  = 1'b0;
    m_drops = 0;
  endtask

  task automatic model_step();
    ent_t e;
    logic rise;
    logic take;
    rise = event_in && !m_prev;
    m_prev = event_in;
    take = (q.size() > 0) && out_ready && !clear;
    if (clear) begin
      q.delete();
      m_over  = 1'b0;
      m_drops = 0;
      m_armed = 1'b1;
      m_last  = '0;
    end
    if (take) void'(q.pop_front());
    if (rise) begin
      if (q.size() < DEPTH) begin
        e.stamp = count;
        e.delta = m_armed ? '0 : CNT_W'(count - m_last);
        e.first = m_armed;
        q.push_back(e);
      end else begin
        m_over  = 1'b1;
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      end
      m_last  = count;
      m_armed = 1'b0;
    end
  endtask

  // Model advance and output comparison once per clock (and on reset assertion).
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
    #1;
    check("valid", 32'(out_valid), 32'(q.size() > 0));
    check("level", 32'(level), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_over));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    if (q.size() > 0) begin
      check("stamp", 32'(out_stamp), 32'(q[0].stamp));
      check("delta", 32'(out_delta), 32'(q[0].delta));
      check("first", 32'(out_first), 32'(q[0].first));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [CNT_W-1:0] c);
    event_in = 1'b1;
    count    = c;
    tick();
    event_in = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; event_in = 1'b1; clear = 1'b0; out_ready = 1'b0; count = '0;
    #1;
    // 1: event held high through reset produces no capture
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_stamp", 32'(out_stamp), 32'd0);
    check("rst_delta", 32'(out_delta), 32'd0);
    check("rst_first", 32'(out_first), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    check("held_level", 32'(level), 32'd0);
    event_in = 1'b0; tick();
    event_in = 1'b1; count = 12'h064; tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_stamp", 32'(out_stamp), 32'h064);
    check("t1_delta", 32'(out_delta), 32'd0);
    check("t1_first", 32'(out_first), 32'd1);
    event_in = 1'b0; out_ready = 1'b1; tick();

    // 2: interval between consecutive events
    event_in = 1'b1; count = 12'h100; tick();
    check("t2a_delta", 32'(out_delta), 32'h09C);
    event_in = 1'b0; tick();
    event_in = 1'b1; count = 12'h1F4; tick();
    check("t2_stamp", 32'(out_stamp), 32'h1F4);
    check("t2_delta", 32'(out_delta), 32'h0F4);
    check("t2_first", 32'(out_first), 32'd0);
    event_in = 1'b0; tick();

    // 3: wrap-aware interval
    pulse(12'hFF0);
    event_in = 1'b1; count = 12'h010; tick();
    check("t3_delta", 32'(out_delta), 32'h020);
    event_in = 1'b0; tick();
    out_ready = 1'b0;
    check("t3_empty", 32'(level), 32'd0);

    // 4: overflow with six events into four slots, then in-order drain
    for (int i = 0; i < 6; i++) pulse(CNT_W'(12'h200 + 8 * i));
    check("t4_level", 32'(level), 32'd4);
    check("t4_over", 32'(overflow), 32'd1);
    check("t4_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("t4_order", 32'(out_stamp), 32'(12'h200 + 8 * i));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    check("t4_drained", 32'(out_valid), 32'd0);

    // 5: edge on a full FIFO accepted thanks to a simultaneous pop
    for (int i = 0; i < 4; i++) pulse(CNT_W'(12'h300 + 4 * i));
    event_in = 1'b1; out_ready = 1'b1; count = 12'h340; tick();
    event_in = 1'b0; out_ready = 1'b0;
    check("t5_level", 32'(level), 32'd4);
    check("t5_over", 32'(overflow), 32'd1);
    check("t5_drop", 32'(drop_cnt), 32'd2);
    check("t5_head", 32'(out_stamp), 32'h304);
    tick();

    // 6: clear coincident with an edge, then async reset mid-drain
    clear = 1'b1; event_in = 1'b1; count = 12'h321; tick();
    clear = 1'b0; event_in = 1'b0;
    check("t6_level", 32'(level), 32'd1);
    check("t6_stamp", 32'(out_stamp), 32'h321);
    check("t6_first", 32'(out_first), 32'd1);
    check("t6_delta", 32'(out_delta), 32'd0);
    check("t6_over", 32'(overflow), 32'd0);
    check("t6_drop", 32'(drop_cnt), 32'd0);
    tick();
    pulse(12'h400);
    pulse(12'h410);
    out_ready = 1'b1; tick();
    reset = 1'b1; #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_level", 32'(level), 32'd0);
    tick();
    reset = 1'b0; out_ready = 1'b0; event_in = 1'b0;
    tick();

    // Randomized traffic against the model; counter free-runs and wraps.
    count = '0;
    for (int c = 0; c < 6000; c++) begin
      count     = count + 12'd1;
      event_in  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1; #1; reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    clear = 1'b0; event_in = 1'b0; out_ready = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
